// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU execution stage.
package alu_pkg;

  localparam int unsigned DATA_W = 32'd8;
  localparam int unsigned ADDR_W = 32'd4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_WB      = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Operand/request inputs and register-file write-back port of the ALU stage.
interface alu_exec_if #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned ADDR_W = alu_pkg::ADDR_W
);

  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] ALUResult;
  logic [ADDR_W-1:0] WA;
  logic              write_enable;
  logic              zero;
  logic              busy;

  modport master (
    output start, op, RD1, RD2, dest,
    input  ALUResult, WA, write_enable, zero, busy
  );

  modport slave (
    input  start, op, RD1, RD2, dest,
    output ALUResult, WA, write_enable, zero, busy
  );

endinterface

// File: rtl/mul_iter.sv
// Shift-add multiplier: eight iterations, one per cycle, low DATA_W bits kept.
// done flags the cycle whose edge commits the final iteration; product is that sum.
module mul_iter #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              load,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] product,
  output logic              done
);

  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] mcand_r;
  logic [DATA_W-1:0] mplier_r;
  logic [2:0]        cnt_r;
  logic              run_r;
  logic [DATA_W-1:0] partial_s;

  assign partial_s = mplier_r[0] ? mcand_r : {DATA_W{1'b0}};
  assign product   = acc_r + partial_s;
  assign done      = run_r & (cnt_r == 3'd7);

  // Operand capture on load, then one shift-add step per cycle while running
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_r    <= {DATA_W{1'b0}};
      mcand_r  <= {DATA_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};
      cnt_r    <= 3'd0;
      run_r    <= 1'b0;
    end else if (load) begin
      acc_r    <= {DATA_W{1'b0}};
      mcand_r  <= a;
      mplier_r <= b;
      cnt_r    <= 3'd0;
      run_r    <= 1'b1;
    end else if (run_r) begin
      acc_r    <= product;
      mcand_r  <= mcand_r << 1'b1;
      mplier_r <= mplier_r >> 1'b1;
      cnt_r    <= cnt_r + 3'd1;
      run_r    <= (cnt_r != 3'd7);
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
      run_r    <= run_r;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution stage: single-cycle logic/arith ops, iterative multiply,
// registered write-back port held stable between write-back cycles.
module alu_exec #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned ADDR_W = alu_pkg::ADDR_W
) (
  input logic       CLK,
  input logic       RESET_N,
  alu_exec_if.slave bus
);

  import alu_pkg::*;

  alu_state_e        state_r;
  alu_state_e        state_n;
  alu_op_e           op_s;
  logic [2:0]        shamt_s;
  logic [DATA_W-1:0] alu_s;
  logic [DATA_W-1:0] product_s;
  logic [DATA_W-1:0] wb_result_s;
  logic [ADDR_W-1:0] wb_addr_s;
  logic              mul_load_s;
  logic              mul_done_s;
  logic              wb_load_s;
  logic [DATA_W-1:0] result_r;
  logic [ADDR_W-1:0] wa_r;
  logic [ADDR_W-1:0] dest_r;
  logic              zero_r;
  logic              we_r;
  logic              busy_r;

  assign op_s    = alu_op_e'(bus.op);
  assign shamt_s = bus.RD2[2:0];

  // Single-cycle result from the live inputs, registered on the accepting edge
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    case (op_s)
      OP_ADD:  alu_s = bus.RD1 + bus.RD2;
      OP_SUB:  alu_s = bus.RD1 - bus.RD2;
      OP_AND:  alu_s = bus.RD1 & bus.RD2;
      OP_OR:   alu_s = bus.RD1 | bus.RD2;
      OP_XOR:  alu_s = bus.RD1 ^ bus.RD2;
      OP_SLL:  alu_s = bus.RD1 << shamt_s;
      OP_SRL:  alu_s = bus.RD1 >> shamt_s;
      OP_MUL:  alu_s = {DATA_W{1'b0}};
      default: alu_s = {DATA_W{1'b0}};
    endcase
  end

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .load    (mul_load_s),
    .a       (bus.RD1),
    .b       (bus.RD2),
    .product (product_s),
    .done    (mul_done_s)
  );

  // Next state and write-back selection; start is only honoured in IDLE or WB
  always_comb begin
    state_n     = state_r;
    mul_load_s  = 1'b0;
    wb_load_s   = 1'b0;
    wb_result_s = alu_s;
    wb_addr_s   = bus.dest;
    case (state_r)
      ST_IDLE, ST_WB: begin
        if (bus.start) begin
          if (op_s == OP_MUL) begin
            state_n    = ST_MUL_RUN;
            mul_load_s = 1'b1;
          end else begin
            state_n   = ST_WB;
            wb_load_s = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_MUL_RUN: begin
        wb_result_s = product_s;
        wb_addr_s   = dest_r;
        if (mul_done_s) begin
          state_n   = ST_WB;
          wb_load_s = 1'b1;
        end else begin
          state_n = ST_MUL_RUN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Write-back outputs; result/address/zero only change when entering WB
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      result_r <= {DATA_W{1'b0}};
      wa_r     <= {ADDR_W{1'b0}};
      dest_r   <= {ADDR_W{1'b0}};
      zero_r   <= 1'b1;
      we_r     <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      we_r   <= wb_load_s;
      busy_r <= (state_n == ST_MUL_RUN);
      if (mul_load_s) begin
        dest_r <= bus.dest;
      end else begin
        dest_r <= dest_r;
      end
      if (wb_load_s) begin
        result_r <= wb_result_s;
        wa_r     <= wb_addr_s;
        zero_r   <= (wb_result_s == {DATA_W{1'b0}});
      end else begin
        result_r <= result_r;
        wa_r     <= wa_r;
        zero_r   <= zero_r;
      end
    end
  end

  assign bus.ALUResult    = result_r;
  assign bus.WA           = wa_r;
  assign bus.zero         = zero_r;
  assign bus.write_enable = we_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_alu_exec.sv
// Directed and random checks of alu_exec against an arithmetic reference model.
module tb_alu_exec;

  localparam int DW = 8;
  localparam int AW = 4;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  alu_exec_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  alu_exec #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a * (2 ** (b % 8))) % 256;
      6: return a / (2 ** (b % 8));
      7: return (a * b) % 256;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_lat(input int op);
    return (op == 7) ? 9 : 1;
  endfunction

  task automatic drive(input int op, input int a, input int b, input int d);
    bus.op    = 3'(op);
    bus.RD1   = 8'(a);
    bus.RD2   = 8'(b);
    bus.dest  = 4'(d);
    bus.start = 1'b1;
  endtask

  // Called just after the accepting edge; waits (bounded) for the write-back pulse.
  task automatic expect_wb(input string tag, input int op, input int a, input int b, input int d);
    int lat    = 1;
    int busy_n = 0;
    int exp_r  = ref_alu(op, a, b);
    while (bus.write_enable !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_n++;
      step();
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, ".latency"}, lat, ref_lat(op));
    chk({tag, ".busy_cycles"}, busy_n, (op == 7) ? 8 : 0);
    chk({tag, ".result"}, bus.ALUResult, exp_r);
    chk({tag, ".wa"}, bus.WA, d);
    chk({tag, ".zero"}, bus.zero, (exp_r == 0) ? 1 : 0);
    chk({tag, ".busy_in_wb"}, bus.busy, 0);
    step();
    chk({tag, ".we_one_cycle"}, bus.write_enable, 0);
    chk({tag, ".result_held"}, bus.ALUResult, exp_r);
  endtask

  initial begin
    int n_we;
    int op, a, b, d;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.RD1   = 8'd0;
    bus.RD2   = 8'd0;
    bus.dest  = 4'd0;

    // Reset takes effect without any clock edge
    #1 RESET_N = 1'b0;
    #1;
    chk("rst.result", bus.ALUResult, 0);
    chk("rst.wa", bus.WA, 0);
    chk("rst.we", bus.write_enable, 0);
    chk("rst.zero", bus.zero, 1);
    chk("rst.busy", bus.busy, 0);
    step();
    step();
    RESET_N = 1'b1;

    drive(0, 3, 5, 2);     step(); expect_wb("add", 0, 3, 5, 2);
    drive(1, 5, 5, 4);     step(); expect_wb("sub_zero", 1, 5, 5, 4);
    drive(1, 0, 1, 6);     step(); expect_wb("sub_wrap", 1, 0, 1, 6);
    drive(5, 1, 11, 7);    step(); expect_wb("sll", 5, 1, 11, 7);
    drive(6, 128, 7, 9);   step(); expect_wb("srl", 6, 128, 7, 9);

    // MUL with start held high and inputs changed while it runs
    drive(7, 13, 11, 15);
    step();
    bus.op   = 3'd0;
    bus.RD1  = 8'd1;
    bus.RD2  = 8'd1;
    bus.dest = 4'd0;
    chk("mul.wa_held", bus.WA, 9);
    chk("mul.result_held", bus.ALUResult, 1);
    chk("mul.we_low", bus.write_enable, 0);
    expect_wb("mul", 7, 13, 11, 15);

    // Back-to-back single-cycle ops
    drive(0, 1, 1, 1);
    step();
    chk("b2b.we1", bus.write_enable, 1);
    chk("b2b.res1", bus.ALUResult, 2);
    chk("b2b.wa1", bus.WA, 1);
    drive(4, 255, 15, 3);
    step();
    chk("b2b.we2", bus.write_enable, 1);
    chk("b2b.res2", bus.ALUResult, 240);
    chk("b2b.wa2", bus.WA, 3);
    bus.start = 1'b0;
    step();
    chk("b2b.we_off", bus.write_enable, 0);
    chk("b2b.hold", bus.ALUResult, 240);

    // Reset in the middle of a multiply
    drive(7, 200, 3, 5);
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    #1 RESET_N = 1'b0;
    #1;
    chk("abort.result", bus.ALUResult, 0);
    chk("abort.wa", bus.WA, 0);
    chk("abort.we", bus.write_enable, 0);
    chk("abort.zero", bus.zero, 1);
    chk("abort.busy", bus.busy, 0);
    step();
    step();
    RESET_N = 1'b1;
    n_we = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.write_enable !== 1'b0) n_we++;
    end
    chk("abort.no_we_after", n_we, 0);
    chk("abort.idle_busy", bus.busy, 0);

    // Start presented across reset release is taken on the first edge
    RESET_N = 1'b0;
    drive(0, 2, 3, 4);
    #3 RESET_N = 1'b1;
    step();
    expect_wb("post_reset_add", 0, 2, 3, 4);

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      d  = int'($urandom_range(0, 15));
      if (i % 9 == 0) b = a;
      drive(op, a, b, d);
      step();
      expect_wb("rand", op, a, b, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the operand and result width.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning the register address width (16 registers).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit: reset that is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation on the current inputs.
REQ-006 SHALL have port op, input, 3 bits: operation select, using the encodings in REQ-012.
REQ-007 SHALL have port RD1, input, DATA_W bits: operand A, driven from the register file read port 1.
REQ-008 SHALL have port RD2, input, DATA_W bits: operand B, driven from the register file read port 2.
REQ-009 SHALL have port dest, input, ADDR_W bits: the destination register for the result.
REQ-010 SHALL have the following outputs, which together form the write-back port to the register file:
- ALUResult, DATA_W bits: the result.
- WA, ADDR_W bits: the write address.
- write_enable, 1 bit: one-cycle write strobe.
- zero, 1 bit: asserted when ALUResult==0.
REQ-011 SHALL have output busy, 1 bit: asserted while a multiply is in progress.

Function
REQ-012 SHALL decode op as follows, with all 8 codes legal:
- 0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR.
- 5=SLL and 6=SRL, each shifting RD1 by RD2[2:0].
- 7=MUL.
REQ-013 SHALL truncate all arithmetic modulo 2^DATA_W, with no carry or overflow output; MUL SHALL return the low DATA_W bits of the product.
REQ-014 SHALL implement an FSM with states IDLE, MUL_RUN and WB.
REQ-015 SHALL accept start in IDLE or WB, and SHALL ignore start in MUL_RUN.
REQ-016 SHALL capture op, RD1, RD2 and dest on the accepting edge; input changes after that edge SHALL have no effect on the operation in flight.
REQ-017 For non-MUL ops, SHALL move to WB on the accepting edge, so that write_enable=1 with a valid ALUResult, WA and zero during the next cycle (latency 1).
REQ-018 For MUL, SHALL move to MUL_RUN and perform 8 shift-add iterations, one per cycle, with a 3-bit counter running 0..7.
REQ-019 For MUL, SHALL move to WB after the counter reaches 7, giving write_enable 9 cycles after the accepting edge.
REQ-020 SHALL assert write_enable for exactly one cycle per accepted operation, and only in WB.
REQ-021 SHALL hold ALUResult, WA and zero from the last WB until the next WB.
REQ-022 From WB, SHALL go to IDLE if start=0; if start=1, SHALL accept the new op, giving back-to-back single-cycle ops a write_enable on every cycle.
REQ-023 SHALL assert busy=1 exactly while in MUL_RUN.
REQ-024 SHALL derive zero from the same registered result as ALUResult.

Reset
REQ-025 SHALL, on RESET_N=0 and regardless of CLK, immediately force: state=IDLE, ALUResult=0, WA=0, write_enable=0, zero=1, busy=0, counter=0.
REQ-026 SHALL, on reset during MUL_RUN, abort the multiply with no write_enable pulse either during or after reset.
REQ-027 SHALL, on the first rising edge after RESET_N deasserts, be able to accept a start.

Structure
REQ-028 SHALL place the op encoding enum, the state enum, DATA_W and ADDR_W in a shared package alu_pkg.
REQ-029 SHALL implement the iterative multiplier as the sub-module mul_iter, with ports:
- inputs: CLK, RESET_N, load, a, b.
- outputs: product, done.

Verification
REQ-030 SHALL verify ADD: RD1=3, RD2=5, dest=2, start for 1 cycle -> next cycle write_enable=1, ALUResult=8, WA=2, zero=0.
REQ-031 SHALL verify SUB wrap: RD1=5, RD2=5 -> ALUResult=0, zero=1; RD1=0, RD2=1 -> ALUResult=255.
REQ-032 SHALL verify MUL: RD1=13, RD2=11, dest=15 -> busy=1 for 8 cycles, then ALUResult=143 with write_enable 9 cycles after start; a start with op=ADD held high during MUL_RUN -> ignored.
REQ-033 SHALL verify back-to-back: ADD(1,1,dest=1) followed by XOR(255,15,dest=3) on consecutive cycles -> write_enable high for 2 consecutive cycles with ALUResult 2 then 240.
REQ-034 SHALL verify shift: SLL RD1=1, RD2=11 -> ALUResult=8 (shift 3); SRL RD1=128, RD2=7 -> ALUResult=1.
REQ-035 SHALL verify reset abort: RESET_N=0 at cycle 4 of MUL -> outputs reset immediately, no write_enable afterwards, and a new ADD is accepted on the first edge after release.
